// File: rtl/mdsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdsa_pkg
// Description : Shared sizes and launch-FSM state type for the MDSA input loader.
// Revision    : 1.0 - initial release
// ============================================================================
package mdsa_pkg;

    localparam int N         = 8;
    localparam int DW        = 32;
    localparam int NUM_WORDS = N * N;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int START_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/mdsa_loader_bank.sv
`default_nettype none
// ============================================================================
// Module      : mdsa_loader_bank
// Description : One ping-pong bank: word storage, write index and full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdsa_loader_bank #(
    parameter int NUM_WORDS = mdsa_pkg::NUM_WORDS,
    parameter int DW        = mdsa_pkg::DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_data,
    input  logic                    release_en,
    output logic                    wr_last,
    output logic                    full,
    output logic [NUM_WORDS*DW-1:0] block
);
    import mdsa_pkg::*;

    localparam int                 c_IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);

    logic [DW-1:0]      r_mem [NUM_WORDS];
    logic [c_IDX_W-1:0] r_idx;
    logic               r_full;
    logic               w_write;

    // A full bank is never written, which keeps the launched block stable.
    assign w_write = en & wr_en & ~r_full;
    assign wr_last = w_write & (r_idx == c_LAST_IDX);
    assign full    = r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_mem[k] <= '0;
            end
            r_idx  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_idx] <= wr_data;
                if (r_idx == c_LAST_IDX) begin
                    r_idx  <= '0;
                    r_full <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (en & release_en) begin
                r_full <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_pack
            assign block[k*DW +: DW] = r_mem[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mdsa_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : mdsa_input_loader
// Description : Packs a word stream into N*N blocks and launches the sorter.
// Revision    : 1.0 - initial release
// ============================================================================
module mdsa_input_loader #(
    parameter int N         = mdsa_pkg::N,
    parameter int DW        = mdsa_pkg::DW,
    parameter int START_LEN = mdsa_pkg::START_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DW-1:0]       s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [N*N*DW-1:0]   sort_data,
    output logic                sort_start,
    input  logic                sort_rdy,
    input  logic                sort_done,
    output logic                busy
);
    import mdsa_pkg::*;

    localparam int                 c_NUM_WORDS = N * N;
    localparam int                 c_CNT_W     = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(START_LEN - 1);

    logic [1:0]                w_full;
    logic [1:0]                w_wr_en;
    logic [1:0]                w_wr_last;
    logic [1:0]                w_release;
    logic [c_NUM_WORDS*DW-1:0] w_block [2];
    logic                      w_accept;
    logic                      w_done;

    logic                      r_fill_sel;
    logic                      r_launch_sel;
    load_state_t               r_state;
    logic [c_CNT_W-1:0]        r_cnt;

    assign s_ready   = en & ~w_full[r_fill_sel];
    assign w_accept  = s_valid & s_ready;
    assign w_done    = en & (r_state == BUSY) & sort_done;
    assign sort_data = w_block[r_launch_sel];

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign w_wr_en[b]   = w_accept & (r_fill_sel == 1'(b));
            assign w_release[b] = w_done & (r_launch_sel == 1'(b));

            mdsa_loader_bank #(
                .NUM_WORDS (c_NUM_WORDS),
                .DW        (DW)
            ) u_bank (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .wr_en      (w_wr_en[b]),
                .wr_data    (s_data),
                .release_en (w_release[b]),
                .wr_last    (w_wr_last[b]),
                .full       (w_full[b]),
                .block      (w_block[b])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_sel <= 1'b0;
        end else if (|w_wr_last) begin
            r_fill_sel <= ~r_fill_sel;
        end
    end

    // Launch sequencer; sort_done is only honoured once the start burst is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_launch_sel <= 1'b0;
            sort_start   <= 1'b0;
            busy         <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (w_full[r_launch_sel] & sort_rdy) begin
                        r_state    <= START;
                        r_cnt      <= c_CNT_LOAD;
                        sort_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == '0) begin
                        r_state    <= BUSY;
                        sort_start <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BUSY: begin
                    if (sort_done) begin
                        r_state      <= IDLE;
                        busy         <= 1'b0;
                        r_launch_sel <= ~r_launch_sel;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    sort_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdsa_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdsa_input_loader
// Description : Randomized self-checking bench against a block-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdsa_input_loader;

    localparam int N         = 8;
    localparam int DW        = 32;
    localparam int START_LEN = 4;
    localparam int NW        = N * N;
    localparam int BW        = NW * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] sort_data;
    logic          sort_start;
    logic          sort_rdy;
    logic          sort_done;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: completed blocks in arrival order (front = the one being sorted),
    // the block under construction, and the launch progress.
    logic [BW-1:0] m_blocks [$];
    logic [BW-1:0] m_part;
    int            m_pcnt;
    int            m_start_left;
    bit            m_sorting;
    logic [DW-1:0] seq;

    mdsa_input_loader #(
        .N         (N),
        .DW        (DW),
        .START_LEN (START_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sort_data  (sort_data),
        .sort_start (sort_start),
        .sort_rdy   (sort_rdy),
        .sort_done  (sort_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_blocks.delete();
        m_part       = '0;
        m_pcnt       = 0;
        m_start_left = 0;
        m_sorting    = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit acc;
        int nb;
        if (rst) begin
            model_reset();
        end else if (en) begin
            nb  = m_blocks.size();
            acc = s_valid && (nb < 2);
            if (m_start_left > 0) begin
                m_start_left--;
                if (m_start_left == 0) m_sorting = 1'b1;
            end else if (m_sorting) begin
                if (sort_done) begin
                    m_sorting = 1'b0;
                    void'(m_blocks.pop_front());
                end
            end else if (nb > 0 && sort_rdy) begin
                m_start_left = START_LEN;
            end
            if (acc) begin
                m_part[m_pcnt*DW +: DW] = s_data;
                m_pcnt++;
                if (m_pcnt == NW) begin
                    m_blocks.push_back(m_part);
                    m_part = '0;
                    m_pcnt = 0;
                end
            end
        end
    endtask

    task automatic check_data_zero(input string tag);
        for (int k = 0; k < NW; k++) begin
            check(tag, 64'(sort_data[k*DW +: DW]), 64'd0);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input bit do_chk);
        logic [BW-1:0] blk;
        bit            exp_ready;
        bit            exp_busy;
        bit            acc;
        #1;
        exp_ready = en && (m_blocks.size() < 2);
        exp_busy  = (m_start_left > 0) || m_sorting;
        if (do_chk) begin
            check("s_ready", 64'(s_ready), 64'(exp_ready));
            check("sort_start", 64'(sort_start), 64'(m_start_left > 0));
            check("busy", 64'(busy), 64'(exp_busy));
            if (exp_busy && m_blocks.size() > 0) begin
                blk = m_blocks[0];
                for (int k = 0; k < NW; k++) begin
                    check("sort_data", 64'(sort_data[k*DW +: DW]), 64'(blk[k*DW +: DW]));
                end
            end
        end
        acc = !rst && exp_ready && s_valid;
        model_step();
        if (acc) seq = seq + 1'b1;
        @(negedge clk);
    endtask

    task automatic run_phase(input int cycles, input int pv, input int pe,
                             input int pr, input int pd, input bit seq_data);
        for (int i = 0; i < cycles; i++) begin
            s_valid   = ($urandom_range(99) < pv);
            en        = ($urandom_range(99) < pe);
            sort_rdy  = ($urandom_range(99) < pr);
            sort_done = ($urandom_range(99) < pd);
            s_data    = seq_data ? seq : $urandom;
            cycle(1'b1);
        end
    endtask

    initial begin
        bit hit;
        rst       = 1'b1;
        en        = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        sort_rdy  = 1'b1;
        sort_done = 1'b0;
        seq       = 32'd1;
        model_reset();
        @(negedge clk);
        repeat (2) cycle(1'b0);
        rst = 1'b0;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_sort_start", 64'(sort_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_data_zero("rst_sort_data");

        // Back-to-back stream of two blocks with the sorter held busy, then releases.
        seq = 32'd1;
        run_phase(140, 100, 100, 100, 0, 1'b1);
        run_phase(1, 100, 100, 100, 100, 1'b1);
        run_phase(20, 100, 100, 100, 0, 1'b1);
        run_phase(1, 0, 100, 100, 100, 1'b1);
        // Sorter not ready, then ready.
        run_phase(80, 100, 100, 0, 0, 1'b1);
        run_phase(20, 100, 100, 100, 0, 1'b1);

        run_phase(400, 80, 90, 70, 20, 1'b0);
        run_phase(400, 100, 100, 100, 30, 1'b1);
        run_phase(300, 60, 70, 30, 10, 1'b0);
        run_phase(300, 100, 100, 100, 100, 1'b1);

        // Reset in the second START cycle.
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            s_valid   = 1'b1;
            en        = 1'b1;
            sort_rdy  = 1'b1;
            sort_done = 1'b1;
            s_data    = $urandom;
            if (m_start_left == START_LEN - 1) begin
                hit = 1'b1;
                rst = 1'b1;
            end
            cycle(1'b1);
            rst = 1'b0;
        end
        check("reach_start_cycle2", 64'(hit), 64'd1);
        #1;
        check("mid_rst_sort_start", 64'(sort_start), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check_data_zero("mid_rst_sort_data");
        seq = 32'd1;
        run_phase(150, 100, 100, 100, 10, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdsa_input_loader.md
# mdsa_input_loader

Upstream feeder for `MDSA_top`, the 8×8 multidimensional bitonic sorter. It accepts a word-serial valid/ready stream of DW-bit keys and packs each group of N*N words into a flat N*N*DW-bit block. It launches the sorter with a multi-cycle `start` pulse and holds the block stable until the sorter signals completion. Two ping-pong banks let the next block fill while the current one is being sorted.

## Interface
- `N`, 8, sorter dimension; block size is N*N words.
- `DW`, 32, key width in bits.
- `START_LEN`, 4, number of cycles `sort_start` is held high per launch (≥1).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; low freezes all state.
- `s_data`  in  DW  input key.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `sort_data`  out  N*N*DW  packed block to `MDSA_top.data_in`; word k occupies bits [(k+1)*DW-1 : k*DW].
- `sort_start`  out  1  to `MDSA_top.start`.
- `sort_rdy`  in  1  from `MDSA_top.rdy`; high means the sorter is idle and will accept `start`.
- `sort_done`  in  1  from `MDSA_top.output_enable`; high means the result is valid and the block may be released.
- `busy`  out  1  high in START or BUSY state.

## Operation
- **Banks.** Two banks, each holding N*N words, a 6-bit write index (log2(N*N)) and a `full` flag.
  - `fill_sel` selects the bank currently being written; `launch_sel` selects the bank driven on `sort_data`.
- **Fill.**
  - `s_ready = en & ~full[fill_sel]`.
  - On each accept (`s_valid & s_ready`), `s_data` is written to word[index] of `fill_sel`, and index increments.
  - The first word of a block lands in bits [DW-1:0].
  - On the accept of word N*N-1: index wraps to 0, `full[fill_sel]` is set, and `fill_sel` toggles, all on the same edge.
- **Launch FSM**, states IDLE, START, BUSY:
  - IDLE → START when `full[launch_sel] & sort_rdy`. The start counter loads START_LEN-1.
  - START: `sort_start=1`. The counter decrements each cycle; at 0 the FSM moves to BUSY. `sort_done` is ignored in START.
  - BUSY: wait for `sort_done`. On the edge where `sort_done=1`: clear `full[launch_sel]`, toggle `launch_sel`, go to IDLE.
- **Data hold.** `sort_data` is a mux of `launch_sel`'s bank. The loader never writes to a bank while its `full` flag is set, so the block is stable from START until release.
- **`en=0`.** No register changes; `s_ready=0`. `sort_start` and `busy` keep their values, and the START counter pauses.
- **Simultaneous events.**
  - A release (clearing full on one bank) and an accept into the other bank in the same cycle both take effect.
  - If `fill_sel` points at a bank released on that edge, `s_ready` rises in the next cycle.
- **Both banks full.** `s_ready=0` until the next release.

## Timing
- **Reset values** (after the reset edge): `s_ready=en`, `sort_start=0`, `busy=0`, `sort_data=0`. All bank storage and flags are 0, `fill_sel=launch_sel=0`, FSM is IDLE.
- **Reset mid-operation.** Rising `rst` in any state returns to the reset values on the next edge. Partial blocks are discarded.
- **Throughput.** One word per cycle while `s_ready=1`.
- **Launch latency.** The last word of a block is accepted at edge E. `full` is visible after E; `sort_start` rises at E+1 (provided `sort_rdy=1` and the FSM is IDLE) and stays high for exactly START_LEN cycles.
- **Release latency.** `sort_done` is sampled at edge D. `full` clears at D; the next bank, if already full and `sort_rdy=1`, starts at D+1.
- **Streaming.** Zero input bubbles while the sorter releases each bank before the other one fills.

## Structure
- Package `mdsa_pkg`:
  - `N`, `DW`, `NUM_WORDS=N*N`, `IDX_W=$clog2(NUM_WORDS)`;
  - the launch-FSM state enum `{IDLE, START, BUSY}`;
  - `START_LEN` default.
- Sub-module `mdsa_loader_bank`: word storage, write index, `full` flag.
  - Inputs: `wr_en`, `wr_data`, `release`.
  - Outputs: `full`, `block`.
  - Instantiated twice.
- The top level holds `fill_sel`, `launch_sel`, the FSM, the start counter, and the output mux.

## Test plan
- **Reset.** Assert `rst` with `en=1`, `s_valid=0` → after the edge: `sort_start=0`, `busy=0`, `sort_data=0`, `s_ready=1`.
- **Single block.** Stream words 1..64 back-to-back, `sort_rdy=1`.
  - `sort_data[31:0]=1` and `[2047:2016]=64`.
  - `sort_start` high for exactly 4 cycles, rising one edge after `full` sets.
  - `busy` stays 1 until a `sort_done` pulse, then 0.
- **Ping-pong.** Stream 128 words with `sort_done` held low.
  - `s_ready` stays high for all 128 accepts, then drops to 0; only one `sort_start` burst.
  - Pulse `sort_done` → the second burst starts at the next edge, and `sort_data[31:0]=65`.
- **Sorter not ready.** Fill a block with `sort_rdy=0` → no `sort_start` for 10 cycles. Raise `sort_rdy` → `sort_start` rises at the next edge.
- **Enable stall.** Drop `en` after 20 accepts for 5 cycles.
  - `s_ready=0` and the index is frozen.
  - On resume, word 21 lands in bits [671:640].
- **Reset mid-START.** Assert `rst` in the 2nd START cycle → after the edge `sort_start=0`, `busy=0`. A new 64-word block sorts normally.
